// File: rtl/excp_sched.sv
// excp_sched: exception / ERTN commit controller for the LoongArch CSR file.
// Samples the commit stage, prioritises interrupt/exception/ERTN into one
// ECODE/ESUBCODE, pulses the CSR update, drains the pipe, then redirects fetch.
// Optional event counters are enabled by defining EXCP_SCHED_STAT_EN.
module excp_sched #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [4:0]  wb_excp,
  input  logic        wb_ertn,
  input  logic        int_pending,
  input  logic        crmd_ie,
  input  logic [31:0] eentry,
  input  logic [31:0] era,
  output logic        commit_allow,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [5:0]  ecode,
  output logic [2:0]  esubcode,
  output logic [31:0] epc,
  output logic        flush_pipe,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
`ifdef EXCP_SCHED_STAT_EN
  ,
  output logic [31:0] excp_count,
  output logic [31:0] ertn_count
`endif
);

  localparam int unsigned CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_ALE  = 6'h09;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_DRAIN    = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        kind_exc_q, kind_exc_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [2:0]  esub_q, esub_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] rpc_q, rpc_d;
  logic        excp_flush_q, excp_flush_d;
  logic        ertn_flush_q, ertn_flush_d;
  logic        flush_pipe_q, flush_pipe_d;
  logic        rvalid_q, rvalid_d;
  logic        commit_allow_q, commit_allow_d;
  logic        busy_q, busy_d;

  logic        take_int;
  logic        is_exc;
  logic        evt;
  logic        enter_flush;
  logic [5:0]  sel_ecode;

  assign take_int    = int_pending & crmd_ie;
  assign is_exc      = take_int | (|wb_excp);
  assign evt         = wb_valid & (is_exc | wb_ertn);
  assign enter_flush = (state_q == S_IDLE) & evt;

  // Fixed-priority exception code selection (interrupt highest, ALE lowest).
  always_comb begin
    sel_ecode = ECODE_INT;
    if (take_int)        sel_ecode = ECODE_INT;
    else if (wb_excp[0]) sel_ecode = ECODE_ADEF;
    else if (wb_excp[1]) sel_ecode = ECODE_INE;
    else if (wb_excp[2]) sel_ecode = ECODE_SYS;
    else if (wb_excp[3]) sel_ecode = ECODE_BRK;
    else if (wb_excp[4]) sel_ecode = ECODE_ALE;
  end

  // Next-state, event latching and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_exc_d = kind_exc_q;
    ecode_d    = ecode_q;
    esub_d     = esub_q;
    epc_d      = epc_q;
    rpc_d      = rpc_q;

    case (state_q)
      S_IDLE: begin
        if (evt) begin
          state_d    = S_FLUSH;
          kind_exc_d = is_exc;
          ecode_d    = is_exc ? sel_ecode : 6'h00;
          esub_d     = 3'd0;
          epc_d      = wb_pc;
        end
      end
      S_FLUSH: begin
        if (DRAIN_CYCLES > 0) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES);
        end else begin
          state_d = S_REDIRECT;
          rpc_d   = kind_exc_q ? eentry : era;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_REDIRECT;
          rpc_d   = kind_exc_q ? eentry : era;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    excp_flush_d   = (state_d == S_FLUSH) & kind_exc_d;
    ertn_flush_d   = (state_d == S_FLUSH) & ~kind_exc_d;
    flush_pipe_d   = (state_d != S_IDLE);
    rvalid_d       = (state_d == S_REDIRECT);
    commit_allow_d = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      kind_exc_q     <= 1'b0;
      ecode_q        <= 6'h00;
      esub_q         <= 3'd0;
      epc_q          <= 32'h0;
      rpc_q          <= 32'h0;
      excp_flush_q   <= 1'b0;
      ertn_flush_q   <= 1'b0;
      flush_pipe_q   <= 1'b0;
      rvalid_q       <= 1'b0;
      commit_allow_q <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      kind_exc_q     <= kind_exc_d;
      ecode_q        <= ecode_d;
      esub_q         <= esub_d;
      epc_q          <= epc_d;
      rpc_q          <= rpc_d;
      excp_flush_q   <= excp_flush_d;
      ertn_flush_q   <= ertn_flush_d;
      flush_pipe_q   <= flush_pipe_d;
      rvalid_q       <= rvalid_d;
      commit_allow_q <= commit_allow_d;
      busy_q         <= busy_d;
    end
  end

  assign commit_allow   = commit_allow_q;
  assign excp_flush     = excp_flush_q;
  assign ertn_flush     = ertn_flush_q;
  assign ecode          = ecode_q;
  assign esubcode       = esub_q;
  assign epc            = epc_q;
  assign flush_pipe     = flush_pipe_q;
  assign redirect_valid = rvalid_q;
  assign redirect_pc    = rpc_q;
  assign busy           = busy_q;

`ifdef EXCP_SCHED_STAT_EN
  logic [31:0] excp_cnt_q;
  logic [31:0] ertn_cnt_q;

  // Per-kind event counters, bumped on entry to FLUSH; wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      excp_cnt_q <= 32'h0;
      ertn_cnt_q <= 32'h0;
    end else if (enter_flush) begin
      if (is_exc) excp_cnt_q <= excp_cnt_q + 32'd1;
      else        ertn_cnt_q <= ertn_cnt_q + 32'd1;
    end
  end

  assign excp_count = excp_cnt_q;
  assign ertn_count = ertn_cnt_q;
`else
  // Counters absent; enter_flush only feeds the optional statistics.
  logic unused_enter_flush;
  assign unused_enter_flush = enter_flush;
`endif

endmodule
